// File: rtl/bram_arbiter_if.sv
// Requester and RAM-side signal bundle for the two-port BRAM arbiter.
interface bram_arbiter_if #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 9
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic                     req0_write;
    logic [RAM_ADDR_BITS-1:0] req0_addr;
    logic [RAM_WIDTH-1:0]     req0_wdata;
    logic                     rsp0_valid;
    logic [RAM_WIDTH-1:0]     rsp0_data;

    logic                     req1_valid;
    logic                     req1_ready;
    logic                     req1_write;
    logic [RAM_ADDR_BITS-1:0] req1_addr;
    logic [RAM_WIDTH-1:0]     req1_wdata;
    logic                     rsp1_valid;
    logic [RAM_WIDTH-1:0]     rsp1_data;

    logic                     ram_enable;
    logic                     ram_write_enable;
    logic [RAM_ADDR_BITS-1:0] ram_address;
    logic [RAM_WIDTH-1:0]     ram_input_data;
    logic [RAM_WIDTH-1:0]     ram_output_data;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_data,
        output ram_enable, ram_write_enable, ram_address, ram_input_data,
        input  ram_output_data
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  ram_enable, ram_write_enable, ram_address, ram_input_data,
        output ram_output_data
    );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sequencing fetch and load/store accesses
// onto one single-port synchronous BRAM.
module bram_arbiter #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 9
) (
    input logic           clock,
    input logic           reset,
    bram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state, state_n;

    logic                     last_grant;
    logic                     lat_id;
    logic                     lat_write;
    logic [RAM_ADDR_BITS-1:0] lat_addr;
    logic [RAM_WIDTH-1:0]     lat_wdata;

    logic can_accept;
    logic gnt0, gnt1;
    logic hs0, hs1, hs;

    // On a tie the requester not served last wins.
    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign can_accept     = !reset && (state != ACCESS);
    assign bus.req0_ready = can_accept && gnt0;
    assign bus.req1_ready = can_accept && gnt1;

    assign hs0 = bus.req0_valid && bus.req0_ready;
    assign hs1 = bus.req1_valid && bus.req1_ready;
    assign hs  = hs0 || hs1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_n;
            if (hs) begin
                last_grant <= hs1;
                lat_id     <= hs1;
                lat_write  <= hs1 ? bus.req1_write : bus.req0_write;
                lat_addr   <= hs1 ? bus.req1_addr  : bus.req0_addr;
                lat_wdata  <= hs1 ? bus.req1_wdata : bus.req0_wdata;
            end
        end
    end

    always_comb begin
        state_n              = state;
        bus.ram_enable       = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.rsp0_valid       = 1'b0;
        bus.rsp1_valid       = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = hs ? ACCESS : IDLE;
            end
            ACCESS: begin
                bus.ram_enable       = 1'b1;
                bus.ram_write_enable = lat_write;
                state_n              = RESPOND;
            end
            RESPOND: begin
                bus.rsp0_valid = !lat_id;
                bus.rsp1_valid = lat_id;
                state_n        = hs ? ACCESS : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latched request only changes on a handshake, so the pins hold between accesses.
    assign bus.ram_address    = lat_addr;
    assign bus.ram_input_data = lat_wdata;
    assign bus.rsp0_data      = bus.ram_output_data;
    assign bus.rsp1_data      = bus.ram_output_data;
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester arbiter/sequencer in front of one single-port synchronous BRAM (enable, write-enable, 1-cycle registered read, read-before-write on write cycles).
- Requester 0 is the instruction-fetch path and requester 1 is the data load/store path of the 16-bit CPU.
- Grants one access at a time with round-robin fairness, drives the RAM control pins, and routes the read data back to the winner with a response pulse.

Parameters:
RAM_WIDTH, 16, data word width in bits; must match the attached RAM.
RAM_ADDR_BITS, 9, address width; must match the attached RAM.

Ports:
clock  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a request pending.
req0_ready  output  1  request 0 accepted this cycle.
req0_write  input  1  1 = write, 0 = read.
req0_addr  input  RAM_ADDR_BITS  request 0 address.
req0_wdata  input  RAM_WIDTH  request 0 write data.
rsp0_valid  output  1  one-cycle response pulse for requester 0.
rsp0_data  output  RAM_WIDTH  RAM read data; meaningful only while rsp0_valid is high.
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_data: identical to the requester 0 ports, for requester 1.
ram_enable  output  1  to the RAM enable input.
ram_write_enable  output  1  to the RAM write-enable input.
ram_address  output  RAM_ADDR_BITS  to the RAM address input.
ram_input_data  output  RAM_WIDTH  to the RAM write-data input.
ram_output_data  input  RAM_WIDTH  from the RAM read-data output.

Behaviour:
- State machine states:
  - IDLE: no access in flight.
  - ACCESS: RAM is being driven this cycle.
  - RESPOND: RAM data is valid this cycle.
- Acceptance:
  - reqN_ready is high only in IDLE or RESPOND, and only for the granted requester.
  - Handshake for requester N is reqN_valid && reqN_ready.
  - At the handshake edge, latch write, addr, wdata and the grant id into registers.
  - Next state on a handshake is ACCESS; otherwise IDLE.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, grant the requester not served last (last_grant register).
  - last_grant updates only on a handshake.
  - Reset sets last_grant=1, so requester 0 wins the first tie.
  - Grant is combinational from the valids and last_grant; at most one ready is high per cycle.
- ACCESS:
  - ram_enable=1, ram_write_enable = latched write.
  - ram_address and ram_input_data come from the latched registers.
  - Unconditional transition to RESPOND.
- RAM pins outside ACCESS:
  - ram_enable=0 and ram_write_enable=0.
  - ram_address and ram_input_data hold their last values.
- RESPOND:
  - rsp<id>_valid=1 for exactly this cycle.
  - rsp0_data = rsp1_data = ram_output_data (pass-through).
  - For a write, the response is the write acknowledge and the data is the old contents (read-before-write).
  - New handshake in RESPOND -> ACCESS (back-to-back); otherwise -> IDLE.
- Timing:
  - Handshake at cycle T -> ram_enable at T+1 -> rspN_valid at T+2.
  - Sustained throughput is one access per 2 cycles.
- Requester obligations: addr, wdata and write must be stable only during the handshake cycle. A requester may drop valid without a handshake; nothing is issued.
- Reset:
  - Next edge: state=IDLE, last_grant=1, all valid/ready/enable outputs 0, latched address/data registers 0.
  - Reset during ACCESS or RESPOND abandons the access; no response pulse is emitted after reset.
  - A write whose ACCESS cycle already occurred is committed in the RAM.
- Never both rsp0_valid and rsp1_valid in the same cycle; at most one access in flight.

Test Plan:
- Reset, then req0 read addr 0x005, where RAM[5] is preloaded 0x1234 -> req0_ready at T, ram_enable at T+1 with address 0x005, rsp0_valid at T+2 with rsp0_data=0x1234, rsp1_valid never high.
- req1 write addr 0x1FF data 0xBEEF, then req1 read 0x1FF -> write response carries the old contents; the read returns 0xBEEF; ram_write_enable is high only in the write's ACCESS cycle.
- Both requesters hold valid continuously, 6 reads -> grants in order 0,1,0,1,0,1; a handshake every 2 cycles; each response carries its own address's data.
- req0 issued with no contention three times, then both valid -> requester 1 wins the tie (last_grant=0).
- Assert reset in the ACCESS cycle of a req0 read -> no rsp0_valid afterwards; all outputs 0; a fresh req1 read after reset completes normally with 2-cycle latency.
- req0_valid pulsed for one cycle while req1 holds the grant in ACCESS -> no req0 handshake, no req0 response, no extra RAM access.
